// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared 32-source internal bus, one dead cycle between owners.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (forced rotation after MAX_HOLD grant cycles when others wait).
module bus_arbiter #(
  parameter int NUM_REQ  = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               valid_q;

  logic               win_found_d;
  logic [SEL_W-1:0]   win_idx_d;
  logic [SEL_W-1:0]   cand_d;
  logic [NUM_REQ-1:0] win_onehot_d;
  logic               owner_req_d;
  logic               revoke_d;

  if (SEL_W != $clog2(NUM_REQ)) begin : g_bad_sel_w
    $error("bus_arbiter: SEL_W must equal log2(NUM_REQ)");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be at least 2");
  end

  // Rotating priority search: first set req bit starting at ptr_q, wrapping through the top index.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_d = ptr_q + SEL_W'(i);
      if (!win_found_d && req[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end else begin
        win_found_d = win_found_d;
      end
    end
  end

  assign win_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_d;
  assign owner_req_d  = req[sel_q];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt_q;

  // An owner at its last allowed cycle loses the bus only if someone else is waiting.
  assign revoke_d = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && (|(req & ~grant_q));
`else
  assign revoke_d = 1'b0;
`endif

  // Arbiter FSM with registered grant, select, valid and round-robin pointer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      valid_q    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_TURN: begin
          if (en && win_found_d) begin
            state_q    <= ST_GRANT;
            grant_q    <= win_onehot_d;
            sel_q      <= win_idx_d;
            valid_q    <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Release (or forced rotation) opens the one-cycle dead gap before the next owner.
          if (!owner_req_d || revoke_d) begin
            state_q <= ST_TURN;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
          end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
              hold_cnt_q <= hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
            end
`endif
            state_q <= ST_GRANT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven cycle vectors through an expected-value queue, plus hand-written corner sequences.
module tb_bus_arbiter;

  localparam int NUM_REQ  = 32;
  localparam int SEL_W    = 5;
  localparam int MAX_HOLD = 8;

  logic               clk;
  logic               clr;
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               bus_valid;

  int checks;
  int errors;

  typedef struct {
    logic               do_rst;
    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               valid;
  } vec_t;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               valid;
    string              tag;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  bus_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [31:0] rq,
                     input logic [31:0] g, input logic [4:0] s, input logic v);
    vec_t t;
    t.do_rst = r; t.en = e; t.req = rq; t.grant = g; t.sel = s; t.valid = v;
    vecs.push_back(t);
  endtask

  task automatic compare(input string tag, input logic [31:0] eg, input logic [4:0] es, input logic ev);
    checks++;
    if (grant !== eg || sel !== es || bus_valid !== ev) begin
      errors++;
      $display("FAIL %s: got grant=%h sel=%0d valid=%b, want grant=%h sel=%0d valid=%b",
               tag, grant, sel, bus_valid, eg, es, ev);
    end
    checks++;
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL %s_onehot: got grant=%h, want zero or one-hot", tag, grant);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; en = 1'b0; req = '0;
    #2;
    compare("reset", 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic step(input logic e, input logic [31:0] r, input logic [31:0] eg,
                      input logic [4:0] es, input logic ev, input string tag);
    exp_t x;
    @(negedge clk);
    en = e; req = r;
    x.grant = eg; x.sel = es; x.valid = ev; x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got empty queue, want an expected record", tag);
    end else begin
      x = exp_q.pop_front();
      compare(x.tag, x.grant, x.sel, x.valid);
    end
  endtask

  initial begin
    logic [31:0] ones;
    logic [31:0] onehot;
    logic [4:0]  cur;
    logic [4:0]  nxt;
    checks = 0; errors = 0;
    clr = 1'b0; en = 1'b0; req = '0;

    // single requester 4: 1-cycle latency, release, TURN, IDLE
    add(1, 1, 32'h0000_0010, 32'h0000_0010, 5'd4, 1);
    add(0, 1, 32'h0000_0010, 32'h0000_0010, 5'd4, 1);
    add(0, 1, 32'h0000_0010, 32'h0000_0010, 5'd4, 1);
    add(0, 1, 32'h0000_0000, 32'h0000_0000, 5'd4, 0);
    add(0, 1, 32'h0000_0000, 32'h0000_0000, 5'd4, 0);
    add(0, 1, 32'h0000_0000, 32'h0000_0000, 5'd4, 0);
    // requesters 0 and 31 alternate, pointer wraps 31 -> 0
    add(1, 1, 32'h8000_0001, 32'h0000_0001, 5'd0, 1);
    add(0, 1, 32'h8000_0001, 32'h0000_0001, 5'd0, 1);
    add(0, 1, 32'h8000_0000, 32'h0000_0000, 5'd0, 0);
    add(0, 1, 32'h8000_0001, 32'h8000_0000, 5'd31, 1);
    add(0, 1, 32'h8000_0001, 32'h8000_0000, 5'd31, 1);
    add(0, 1, 32'h0000_0001, 32'h0000_0000, 5'd31, 0);
    add(0, 1, 32'h8000_0001, 32'h0000_0001, 5'd0, 1);
    add(0, 1, 32'h8000_0001, 32'h0000_0001, 5'd0, 1);
    add(0, 1, 32'h8000_0000, 32'h0000_0000, 5'd0, 0);
    add(0, 1, 32'h8000_0001, 32'h8000_0000, 5'd31, 1);
    add(0, 1, 32'h8000_0001, 32'h8000_0000, 5'd31, 1);
    add(0, 1, 32'h0000_0000, 32'h0000_0000, 5'd31, 0);
    add(0, 1, 32'h0000_0000, 32'h0000_0000, 5'd31, 0);
    // en low while owner 5 holds: keeps grant, no new grant until en returns
    add(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1);
    add(0, 0, 32'h0000_0060, 32'h0000_0020, 5'd5, 1);
    add(0, 0, 32'h0000_0060, 32'h0000_0020, 5'd5, 1);
    add(0, 0, 32'h0000_0040, 32'h0000_0000, 5'd5, 0);
    add(0, 0, 32'h0000_0040, 32'h0000_0000, 5'd5, 0);
    add(0, 0, 32'h0000_0040, 32'h0000_0000, 5'd5, 0);
    add(0, 1, 32'h0000_0040, 32'h0000_0040, 5'd6, 1);
    add(0, 1, 32'h0000_0040, 32'h0000_0040, 5'd6, 1);
    // a requester that drops before being granted is skipped
    add(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);
    add(0, 0, 32'h0000_0100, 32'h0000_0000, 5'd0, 0);
    add(0, 1, 32'h0000_0200, 32'h0000_0200, 5'd9, 1);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      step(vecs[i].en, vecs[i].req, vecs[i].grant, vecs[i].sel, vecs[i].valid,
           $sformatf("vec%0d", i));
    end

    // all 32 requesters, each releasing after one grant cycle
    do_reset();
    ones = 32'hFFFF_FFFF;
    step(1'b1, ones, 32'h0000_0001, 5'd0, 1'b1, "rr_first");
    cur = 5'd0;
    for (int i = 0; i < 32; i++) begin
      onehot = 32'h0000_0001 << cur;
      nxt    = cur + 5'd1;
      step(1'b1, ones & ~onehot, 32'h0, cur, 1'b0, $sformatf("rr_turn%0d", i));
      step(1'b1, ones, 32'h0000_0001 << nxt, nxt, 1'b1, $sformatf("rr_grant%0d", i));
      cur = nxt;
    end

    // asynchronous clear in the middle of owner 12's grant
    do_reset();
    step(1'b1, 32'h0000_1000, 32'h0000_1000, 5'd12, 1'b1, "clr_grant12");
    step(1'b1, 32'h0000_1008, 32'h0000_1000, 5'd12, 1'b1, "clr_hold12");
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    compare("clr_async", 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    step(1'b1, 32'h0000_1008, 32'h0000_0008, 5'd3, 1'b1, "clr_restart");

`ifdef BUS_ARB_TIMEOUT_EN
    // forced rotation after MAX_HOLD grant cycles when requester 9 waits
    do_reset();
    step(1'b1, 32'h0000_0204, 32'h0000_0004, 5'd2, 1'b1, "to_grant2");
    for (int i = 1; i < MAX_HOLD; i++) begin
      step(1'b1, 32'h0000_0204, 32'h0000_0004, 5'd2, 1'b1, $sformatf("to_hold%0d", i));
    end
    step(1'b1, 32'h0000_0204, 32'h0000_0000, 5'd2, 1'b0, "to_revoke");
    step(1'b1, 32'h0000_0204, 32'h0000_0200, 5'd9, 1'b1, "to_grant9");
    // a lone owner is never revoked
    do_reset();
    step(1'b1, 32'h0000_0004, 32'h0000_0004, 5'd2, 1'b1, "lone_grant2");
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      step(1'b1, 32'h0000_0004, 32'h0000_0004, 5'd2, 1'b1, $sformatf("lone_hold%0d", i));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 32-source internal bus.
- Takes up to 32 drive requests (register/unit "out" strobes) and grants exactly one requester at a time.
- Produces the one-hot grant and the 5-bit encoded select that feeds the 32-to-1 bus multiplexer select input.
- Inserts one dead cycle between owners so the bus never changes source mid-transfer.

Parameters:
- NUM_REQ, 32, number of requesters (power of 2).
- SEL_W, 5, select width; must equal log2(NUM_REQ).
- MAX_HOLD, 8, maximum consecutive GRANT cycles for one owner before forced rotation (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants but does not revoke the current grant.
- req  input  NUM_REQ  request vector; a requester holds its bit high for as long as it needs the bus.
- grant  output  NUM_REQ  one-hot grant, registered.
- sel  output  SEL_W  encoded index of the current/last owner, registered; drives the bus mux select.
- bus_valid  output  1  high when grant is nonzero (bus carries owner data).

Behaviour:
- Reset (clr low, async): state=IDLE, grant=0, sel=0, bus_valid=0, round-robin pointer ptr=0, hold_cnt=0.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If en=1 and req!=0: winner = first set bit of req searching ptr, ptr+1, ... wrapping 31->0.
  - On the next edge: grant=onehot(winner), sel=winner, bus_valid=1, hold_cnt=0, go to GRANT.
  - Latency from req sampled to grant visible: 1 cycle.
  - Otherwise stay in IDLE with outputs unchanged.
- GRANT:
  - While req[sel]=1, hold the grant; hold_cnt increments, saturating at MAX_HOLD.
  - If req[sel]=0 at an edge: on that edge grant=0, bus_valid=0, ptr=(sel+1) mod NUM_REQ, go to TURN.
  - A req drop therefore shows as grant low exactly 1 cycle later.
- TURN:
  - Exactly one cycle with grant=0 and bus_valid=0; sel holds its previous value.
  - Arbitration is evaluated as in IDLE using the updated ptr. If a winner exists and en=1, the grant appears on the next edge (one dead cycle between owners); otherwise go to IDLE.
- en=0 during GRANT: the owner keeps the grant until it releases; the arbiter then goes to TURN, then IDLE, with no new grant until en=1.
- Changes to req bits other than req[sel] during GRANT have no effect on the current grant.
- grant is always zero or one-hot; grant and sel are mutually consistent whenever bus_valid=1.
- Pointer wrap: a release by owner 31 sets ptr=0.
- A requester that drops req before being granted is simply skipped.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronously); after clr rises, arbitration restarts from ptr=0.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt reaches MAX_HOLD-1 and any other req bit is set, the grant is revoked on the next edge exactly as if req[sel] had dropped (TURN, ptr=sel+1).
  - If no other requester is pending, the owner keeps the bus and hold_cnt stays saturated.
- Undefined:
  - hold_cnt logic is not built.
  - The grant is held until the owner drops req, with no upper bound.

Test Plan:
- Reset then req=0x0000_0010 held 3 cycles -> grant=0x10, sel=4, bus_valid=1 one cycle after req; grant drops 1 cycle after req falls; one TURN cycle, then IDLE.
- req=0x8000_0001 constant, each owner releases after 2 GRANT cycles and reasserts -> grants alternate sel=0, 31, 0, 31, with one bus_valid=0 cycle between each; exercises pointer wrap 31->0.
- All 32 req bits high, each releasing after 1 GRANT cycle -> sel visits 0,1,2,...,31,0 in order; grant is never more than one-hot.
- en=0 while owner 5 holds -> owner 5 keeps the grant until release; no new grant while en=0; when en=1 with req[6]=1 -> sel=6 after 1 cycle.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=8, req[2] and req[9] held high -> owner 2 is revoked after 8 GRANT cycles, TURN, then sel=9; with only req[2] high, owner 2 holds indefinitely.
- clr pulsed low mid-GRANT of owner 12 -> grant=0, sel=0, bus_valid=0 immediately; after release with req[12]=1 and req[3]=1 -> first grant is sel=3 (ptr=0).
